// File: rtl/ofmap_deskew_serializer.sv
// ofmap_deskew_serializer
// Receive end of the skewed systolic-array lane protocol. Realigns the
// diagonally skewed lanes, applies ReLU + saturation to 8 bits, buffers whole
// pixels in a FIFO and emits them one byte per cycle (channel 0 first) under
// a valid/ready handshake.
module ofmap_deskew_serializer #(
    parameter int CHANNEL    = 3,
    parameter int ACC_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AFULL_TH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNEL-1:0][ACC_W-1:0]   i_data,
    input  logic [CHANNEL-1:0]              i_valid,
    output logic [7:0]                      o_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_afull,
    output logic                            o_ovf,
    output logic                            o_align_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNEL - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_TH   = CNT_W'(AFULL_TH);

    typedef logic [CHANNEL-1:0][7:0] pix_t;

    // ReLU followed by saturating truncation of one lane to a byte.
    function automatic logic [7:0] post_proc(input logic [ACC_W-1:0] v);
        logic [7:0] r;
        if (v[ACC_W-1]) begin
            r = 8'h00;
        end else if (|v[ACC_W-2:8]) begin
            r = 8'hFF;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    // Stage-A view: every lane after its own deskew delay.
    logic [CHANNEL-1:0][ACC_W-1:0] a_dat_s;
    logic [CHANNEL-1:0]            a_vld_s;

    for (genvar k = 0; k < CHANNEL; k++) begin : g_lane
        // Lane k needs CHANNEL-k stages so all lanes of a pixel meet together.
        localparam int D = CHANNEL - k;
        logic [D-1:0][ACC_W-1:0] dat_q, dat_d;
        logic [D-1:0]            vld_q, vld_d;

        // Shift the lane pipe by one stage per cycle.
        always_comb begin
            dat_d    = dat_q;
            vld_d    = vld_q;
            dat_d[0] = i_data[k];
            vld_d[0] = i_valid[k];
            for (int j = 1; j < D; j++) begin
                dat_d[j] = dat_q[j-1];
                vld_d[j] = vld_q[j-1];
            end
        end

        // Lane pipe registers; reset flushes anything in flight.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dat_q <= '0;
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

        assign a_dat_s[k] = dat_q[D-1];
        assign a_vld_s[k] = vld_q[D-1];
    end

    logic accept_s;
    logic misalign_s;
    pix_t pp_s;

    // Classify the realigned valid vector and post-process the lanes.
    always_comb begin
        accept_s   = &a_vld_s;
        misalign_s = (|a_vld_s) & ~accept_s;
        pp_s       = '0;
        for (int c = 0; c < CHANNEL; c++) begin
            pp_s[c] = post_proc(a_dat_s[c]);
        end
    end

    logic [FIFO_DEPTH-1:0][CHANNEL*8-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       o_data_q, o_data_d;
    logic             o_valid_q, o_valid_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;
    logic             align_q, align_d;
    logic             full_s, wr_s, hs_s, pop_s;
    pix_t             head_s;

    // FIFO write/pop, serializer index and next registered outputs.
    always_comb begin
        full_s   = (count_q == CNT_FULL);
        wr_s     = accept_s & ~full_s;
        hs_s     = o_valid_q & i_ready;
        pop_s    = hs_s & (idx_q == IDX_LAST);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        if (wr_s) begin
            mem_d[wr_ptr_q] = pp_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            idx_d    = {IDX_W{1'b0}};
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (hs_s) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
        count_d   = count_q + CNT_W'(wr_s) - CNT_W'(pop_s);
        o_valid_d = (count_d != {CNT_W{1'b0}});
        head_s    = mem_d[rd_ptr_d];
        if (o_valid_d) begin
            o_data_d = head_s[idx_d];
        end else begin
            o_data_d = 8'h00;
        end
        // Occupancy seen this cycle feeds the flag next cycle.
        afull_d = ((CNT_FULL - count_q) <= CNT_TH);
        ovf_d   = ovf_q | (accept_s & full_s);
        align_d = align_q | misalign_s;
    end

    // FIFO storage, pointers, byte index and all output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            o_data_q  <= 8'h00;
            o_valid_q <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            align_q   <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            align_q   <= align_d;
        end
    end

    assign o_data      = o_data_q;
    assign o_valid     = o_valid_q;
    assign o_afull     = afull_q;
    assign o_ovf       = ovf_q;
    assign o_align_err = align_q;

endmodule

// File: tb/tb_ofmap_deskew_serializer.sv
// Scoreboard bench for ofmap_deskew_serializer: expected bytes are queued
// at pixel launch from a plain-arithmetic model; a negedge monitor compares
// every handshake and checks stability during stalls.
module tb_ofmap_deskew_serializer;

    localparam int CH = 3;
    localparam int AW = 16;
    localparam int DEPTH = 8;
    localparam int TH = 4;

    logic                   clk;
    logic                   rst;
    logic [CH-1:0][AW-1:0]  i_data;
    logic [CH-1:0]          i_valid;
    logic [7:0]             o_data;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_afull;
    logic                   o_ovf;
    logic                   o_align_err;

    ofmap_deskew_serializer #(
        .CHANNEL(CH), .ACC_W(AW), .FIFO_DEPTH(DEPTH), .AFULL_TH(TH)
    ) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_afull(o_afull), .o_ovf(o_ovf), .o_align_err(o_align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    bit mon_en = 0;
    bit rnd_ready = 0;
    logic [7:0] exp_q[$];

    // bench-side skew line: slot s holds the pixel launched s cycles ago
    logic [CH-1:0][AW-1:0] pd [CH];
    logic                  pv [CH];
    logic [CH-1:0]         pm [CH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // software reference: ReLU then clamp to 255
    function automatic logic [7:0] ref_byte(input logic [AW-1:0] raw);
        int v;
        v = int'($signed(raw));
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic cyc(input bit go, input logic [CH-1:0][AW-1:0] px, input logic [CH-1:0] msk);
        for (int s = CH - 1; s > 0; s--) begin
            pd[s] = pd[s-1];
            pv[s] = pv[s-1];
            pm[s] = pm[s-1];
        end
        pd[0] = px;
        pv[0] = go;
        pm[0] = msk;
        for (int k = 0; k < CH; k++) begin
            i_data[k]  = pd[k][k];
            i_valid[k] = pv[k] & pm[k][k];
        end
        if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '1);
    endtask

    task automatic send(input logic [CH-1:0][AW-1:0] px, input bit keep);
        if (keep) begin
            for (int c = 0; c < CH; c++) exp_q.push_back(ref_byte(px[c]));
        end
        cyc(1'b1, px, '1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 1000) begin
            idle(1);
            n++;
        end
        chk({nm, "_drain_timeout"}, 32'(n < 1000), 32'd1);
        chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_line();
        for (int s = 0; s < CH; s++) begin
            pd[s] = '0;
            pv[s] = 1'b0;
            pm[s] = '1;
        end
        i_valid = '0;
        i_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_line();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // monitor: compare each accepted byte and check hold during stalls
    logic [7:0] prev_d;
    bit prev_stall = 0;
    always @(negedge clk) begin
        if (!rst || !mon_en) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_data", 32'(o_data), 32'(prev_d));
            end
            if (o_valid && i_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", o_data);
                end else begin
                    chk("byte", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_d = o_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH-1:0][AW-1:0] px;
        int n;
        int base;
        rst = 1'b1;
        i_ready = 1'b0;
        clear_line();
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_afull", 32'(o_afull), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        chk("rst_align", 32'(o_align_err), 32'd0);
        rst = 1'b1;
        mon_en = 1;

        // single pixel with latency check
        i_ready = 1'b1;
        px[0] = 16'h0012; px[1] = 16'h0034; px[2] = 16'h0056;
        send(px, 1);
        n = 0;
        while (!o_valid && n < 10) begin
            idle(1);
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        drain("single");
        chk("single_valid_low", 32'(o_valid), 32'd0);

        // arithmetic corners
        px[0] = 16'h8001; px[1] = 16'h0100; px[2] = 16'h00FF;
        send(px, 1);
        px[0] = 16'h7FFF; px[1] = 16'h0000; px[2] = 16'h0080;
        send(px, 1);
        drain("arith");

        // misalignment: lane 1 missing from the second pixel
        px[0] = 16'h0011; px[1] = 16'h0022; px[2] = 16'h0033;
        send(px, 1);
        px[0] = 16'h00AA; px[1] = 16'h00BB; px[2] = 16'h00CC;
        cyc(1'b1, px, 3'b101);
        px[0] = 16'h0044; px[1] = 16'h0055; px[2] = 16'h0066;
        send(px, 1);
        px[0] = 16'h0077; px[1] = 16'hF000; px[2] = 16'h0199;
        send(px, 1);
        drain("misalign");
        chk("align_err", 32'(o_align_err), 32'd1);

        // random stall with upstream honouring o_afull
        rnd_ready = 1;
        for (int p = 0; p < 64; p++) begin
            n = 0;
            while (o_afull && n < 500) begin
                idle(1);
                n++;
            end
            if (n >= 500) chk("afull_stuck", 32'(o_afull), 32'd0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 1) == 0) px[c] = AW'($urandom_range(0, 300));
                else px[c] = AW'($urandom_range(0, 65535));
            end
            send(px, 1);
        end
        drain("random");
        rnd_ready = 0;
        i_ready = 1'b1;
        chk("random_ovf", 32'(o_ovf), 32'd0);

        // backpressure and overflow
        do_reset();
        i_ready = 1'b0;
        chk("pre_afull", 32'(o_afull), 32'd0);
        base = hs_cnt;
        for (int p = 0; p < 12; p++) begin
            for (int c = 0; c < CH; c++) px[c] = AW'(16 * p + c + 1);
            send(px, p < 8);
        end
        idle(5);
        chk("ovf_afull", 32'(o_afull), 32'd1);
        chk("ovf_flag", 32'(o_ovf), 32'd1);
        chk("ovf_no_out", 32'(hs_cnt - base), 32'd0);
        i_ready = 1'b1;
        drain("ovf");
        chk("ovf_bytes", 32'(hs_cnt - base), 32'd24);
        idle(2);
        chk("ovf_afull_clear", 32'(o_afull), 32'd0);

        // reset mid-operation with idx = 1
        do_reset();
        i_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < CH; c++) px[c] = AW'(8'hA0 + 16 * p + c);
            send(px, 1);
        end
        idle(4);
        i_ready = 1'b1;
        idle(1);
        i_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_data", 32'(o_data), 32'd0);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_afull", 32'(o_afull), 32'd0);
        chk("mid_rst_ovf", 32'(o_ovf), 32'd0);
        chk("mid_rst_align", 32'(o_align_err), 32'd0);
        clear_line();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        i_ready = 1'b1;
        px[0] = 16'h005A; px[1] = 16'h006B; px[2] = 16'h007C;
        send(px, 1);
        drain("post_rst");
        idle(3);
        chk("post_rst_valid", 32'(o_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofmap_deskew_serializer.md
# ofmap_deskew_serializer

Synthesizable receive end of the skewed systolic-array lane protocol. It takes the diagonally skewed per-lane results of the array (lane k of a pixel arrives k cycles after lane 0) and realigns them. It applies ReLU plus saturating truncation to 8 bits, buffers whole pixels in a FIFO, and serializes them as one byte per cycle in channel order (c=0 first) under a valid/ready handshake. It sits between the array output and the output-feature writeback/checker.

## Interface
- CHANNEL, 3, number of skewed lanes; equals bytes emitted per pixel.
- ACC_W, 16, signed two's-complement lane width; must be ≥ 9.
- FIFO_DEPTH, 8, pixel entries buffered; power of two, ≥ 2.
- AFULL_TH, 4, o_afull asserts when free entries ≤ AFULL_TH; must be ≥ CHANNEL+1 to absorb in-flight pixels.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- i_data  in  [CHANNEL-1:0][ACC_W-1:0]  skewed lane data.
- i_valid  in  [CHANNEL-1:0]  per-lane valid.
- o_data  out  8  serialized post-processed byte.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_afull  out  1  upstream must stop launching new pixels.
- o_ovf  out  1  sticky: pixel dropped because FIFO full.
- o_align_err  out  1  sticky: realigned valid vector was neither all-ones nor all-zeros.

## Operation
- Deskew: lane k passes through (CHANNEL−k) flops (data and valid); lane CHANNEL−1 passes through 1. A pixel whose lane k is sampled at edge T+k is aligned at the stage-A output after edge T+CHANNEL−1.
- Alignment check on the stage-A valid vector:
  - All ones: pixel accepted.
  - All zeros: idle.
  - Any other pattern: set o_align_err and discard the vector.
- Post-processing per lane, combinational from stage A into the FIFO write data:
  - MSB = 1 → 0 (ReLU).
  - Otherwise, if bits [ACC_W−2:8] are nonzero → 8'hFF (saturate).
  - Otherwise → bits [7:0].
- FIFO write: an accepted pixel is written at the next edge if the FIFO is not full. If full, the pixel is dropped, o_ovf is set, and the contents are unchanged.
- Serializer:
  - o_valid = FIFO not empty.
  - o_data = head entry byte[idx], with idx in 0..CHANNEL−1.
  - On o_valid & i_ready: idx increments. When idx = CHANNEL−1, idx wraps to 0 and the head is popped.
  - o_data/o_valid must stay stable while o_valid & !i_ready.
- Simultaneous FIFO write and pop: both occur; occupancy is unchanged. Writing into a full FIFO while the head is popped in the same cycle is an overflow (full is evaluated before the pop).
- o_afull = (FIFO_DEPTH − occupancy) ≤ AFULL_TH, registered.
- Sticky flags clear only on reset.
- Reset (async assert, any time): flushes the deskew pipes, FIFO pointers, occupancy and idx. All outputs go to 0: o_data, o_valid, o_afull, o_ovf and o_align_err. Data in flight is lost. Operation resumes on the first edge after deassertion.

## Timing
- Latency: last lane (CHANNEL−1) sampled at edge E → aligned at E → FIFO written at E+1 → o_valid high after E+1, with byte c=0 on o_data.
- Throughput: input one pixel per cycle; output one pixel per CHANNEL cycles at i_ready = 1. Sustained input therefore fills the FIFO, and upstream must honour o_afull within CHANNEL cycles.
- Back-to-back pixels with continuous i_ready: o_valid stays high with no gap bubbles.
- o_afull, o_ovf and o_align_err update at the edge after the causing event.

## Test plan
- Single pixel, CHANNEL=3, ACC_W=16: lanes {0x0012, 0x0034, 0x0056} driven at cycles T, T+1, T+2, i_ready=1 → o_data 0x12, 0x34, 0x56 on three consecutive cycles starting after edge T+3; o_valid low afterwards.
- Arithmetic: lanes 0x8001 → 0x00, 0x0100 → 0xFF, 0x00FF → 0xFF, 0x7FFF → 0xFF, 0x0000 → 0x00.
- Backpressure and overflow: launch 12 consecutive pixels with i_ready=0 → o_afull rises after occupancy reaches 4; 8 entries are stored; o_ovf = 1. Then raise i_ready → exactly 24 bytes emitted in order, with data held stable during the stall.
- Misalignment: lane 1 valid omitted for one pixel → o_align_err = 1; that pixel is not emitted; the following well-formed pixels are emitted correctly.
- Random stall: 64 random pixels with i_ready toggling pseudo-randomly and upstream obeying o_afull → the output byte stream matches the software ReLU/saturate model exactly; o_ovf = 0.
- Reset mid-operation: assert rst with 3 pixels buffered and idx = 1 → all outputs are 0 immediately (asynchronously). After deassertion, a new pixel emerges with byte c=0 first and no stale data.
